// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared encodings for the pipeline hazard controller:
// stall-cause states, forward selects and the zero register.
package hazard_ctrl_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN = 2'b00,
        ST_LW  = 2'b01,
        ST_BR  = 2'b10,
        ST_ERR = 2'b11
    } stall_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A source can take a later stage's result only if that stage
    // writes the same, non-zero register.
    function automatic logic fwd_hit(
        input logic [4:0] src,
        input logic [4:0] dst,
        input logic       we
    );
        return (src != REG_ZERO) && (src == dst) && we;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// Forward select for one Execute-stage ALU operand.
// Ports: src (operand register), write_reg_m/reg_write_m,
// write_reg_w/reg_write_w, sel (FWD_RF/FWD_WB/FWD_MEM).
module hazard_ctrl_unit_fwd_sel
    import hazard_ctrl_unit_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] write_reg_m,
    input  logic       reg_write_m,
    input  logic [4:0] write_reg_w,
    input  logic       reg_write_w,
    output logic [1:0] sel
);

    // Memory holds the younger result, so it wins over Writeback.
    always_comb begin
        sel = FWD_RF;
        if (fwd_hit(src, write_reg_m, reg_write_m)) begin
            sel = FWD_MEM;
        end else if (fwd_hit(src, write_reg_w, reg_write_w)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline: stall/flush, forward
// selects, stall-cause FSM, consecutive-stall watchdog (sticky error).
// Inputs: register taps rs/rt (D,E), write_reg (E,M,W), control taps,
// cnt_clr. Outputs: stall_f, stall_d, flush_e, forward_ad/bd/ae/be,
// stall_state, hazard_err, lw_stall_cnt, br_stall_cnt.
// HAZARD_PERF_CNT_EN: when defined, builds saturating stall counters;
// otherwise both counter outputs read 0.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int WDOG_MAX = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [4:0]       rs_e,
    input  logic [4:0]       rt_e,
    input  logic [4:0]       write_reg_e,
    input  logic [4:0]       write_reg_m,
    input  logic [4:0]       write_reg_w,
    input  logic             branch_d,
    input  logic             jump_d,
    input  logic             reg_write_e,
    input  logic             memto_reg_e,
    input  logic             reg_write_m,
    input  logic             memto_reg_m,
    input  logic             reg_write_w,
    input  logic             cnt_clr,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             forward_ad,
    output logic             forward_bd,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic [1:0]       stall_state,
    output logic             hazard_err,
    output logic [CNT_W-1:0] lw_stall_cnt,
    output logic [CNT_W-1:0] br_stall_cnt
);

    localparam int RUN_W = $clog2(WDOG_MAX + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WDOG_MAX + 1);

    logic             lwstall;
    logic             brstall;
    logic             stall;
    logic             br_src_e;
    logic             br_src_m;
    logic             run_over;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_next;
    stall_state_t     state_q;

    // A jump resolves in Decode with no register operand.
    logic unused_jump;
    assign unused_jump = jump_d;

    // Register 0 is deliberately not filtered here: a spurious stall
    // only costs a cycle, never correctness.
    assign lwstall = memto_reg_e && (rt_e == rs_d || rt_e == rt_d);

    assign br_src_e = reg_write_e &&
                      (write_reg_e == rs_d || write_reg_e == rt_d);
    assign br_src_m = memto_reg_m &&
                      (write_reg_m == rs_d || write_reg_m == rt_d);
    assign brstall  = branch_d && (br_src_e || br_src_m);

    assign stall   = lwstall || brstall;
    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;

    assign forward_ad = fwd_hit(rs_d, write_reg_m, reg_write_m);
    assign forward_bd = fwd_hit(rt_d, write_reg_m, reg_write_m);

    hazard_ctrl_unit_fwd_sel u_fwd_a (
        .src         (rs_e),
        .write_reg_m (write_reg_m),
        .reg_write_m (reg_write_m),
        .write_reg_w (write_reg_w),
        .reg_write_w (reg_write_w),
        .sel         (forward_ae)
    );

    hazard_ctrl_unit_fwd_sel u_fwd_b (
        .src         (rt_e),
        .write_reg_m (write_reg_m),
        .reg_write_m (reg_write_m),
        .write_reg_w (write_reg_w),
        .reg_write_w (reg_write_w),
        .sel         (forward_be)
    );

    // Run length saturates one past the limit, which is exactly the
    // value that marks a watchdog violation.
    always_comb begin
        run_next = '0;
        if (!cnt_clr && stall) begin
            if (run_q == RUN_MAX) begin
                run_next = RUN_MAX;
            end else begin
                run_next = run_q + 1'b1;
            end
        end
    end

    assign run_over = (run_next == RUN_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            run_q   <= '0;
        end else begin
            run_q <= run_next;
            if (state_q != ST_ERR) begin
                if (run_over) begin
                    state_q <= ST_ERR;
                end else if (lwstall) begin
                    state_q <= ST_LW;
                end else if (brstall) begin
                    state_q <= ST_BR;
                end else begin
                    state_q <= ST_RUN;
                end
            end
        end
    end

    assign stall_state = state_q;
    assign hazard_err  = (state_q == ST_ERR);

`ifdef HAZARD_PERF_CNT_EN
    logic             br_only;
    logic [CNT_W-1:0] lw_q;
    logic [CNT_W-1:0] br_q;

    // A cycle with both causes is charged to the load only.
    assign br_only = brstall && !lwstall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lw_q <= '0;
            br_q <= '0;
        end else if (cnt_clr) begin
            lw_q <= '0;
            br_q <= '0;
        end else begin
            if (lwstall && lw_q != '1) begin
                lw_q <= lw_q + 1'b1;
            end
            if (br_only && br_q != '1) begin
                br_q <= br_q + 1'b1;
            end
        end
    end

    assign lw_stall_cnt = lw_q;
    assign br_stall_cnt = br_q;
`else
    assign lw_stall_cnt = '0;
    assign br_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed testbench for hazard_ctrl_unit (CNT_W=4, WDOG_MAX=2).
// Expected counter values follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, rs_e, rt_e;
    logic [4:0] write_reg_e, write_reg_m, write_reg_w;
    logic       branch_d, jump_d, reg_write_e, memto_reg_e;
    logic       reg_write_m, memto_reg_m, reg_write_w, cnt_clr;
    logic       stall_f, stall_d, flush_e, forward_ad, forward_bd;
    logic [1:0] forward_ae, forward_be, stall_state;
    logic       hazard_err;
    logic [3:0] lw_stall_cnt, br_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.CNT_W(4), .WDOG_MAX(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .write_reg_e  (write_reg_e),
        .write_reg_m  (write_reg_m),
        .write_reg_w  (write_reg_w),
        .branch_d     (branch_d),
        .jump_d       (jump_d),
        .reg_write_e  (reg_write_e),
        .memto_reg_e  (memto_reg_e),
        .reg_write_m  (reg_write_m),
        .memto_reg_m  (memto_reg_m),
        .reg_write_w  (reg_write_w),
        .cnt_clr      (cnt_clr),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_e      (flush_e),
        .forward_ad   (forward_ad),
        .forward_bd   (forward_bd),
        .forward_ae   (forward_ae),
        .forward_be   (forward_be),
        .stall_state  (stall_state),
        .hazard_err   (hazard_err),
        .lw_stall_cnt (lw_stall_cnt),
        .br_stall_cnt (br_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ecnt(input int n);
`ifdef HAZARD_PERF_CNT_EN
        return (n > 15) ? 32'd15 : 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic idle();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
        branch_d = 0; jump_d = 0; reg_write_e = 0; memto_reg_e = 0;
        reg_write_m = 0; memto_reg_m = 0; reg_write_w = 0;
        cnt_clr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stall(input string tag, input logic exp);
        check({tag, "_f"}, 32'(stall_f), 32'(exp));
        check({tag, "_d"}, 32'(stall_d), 32'(exp));
        check({tag, "_fl"}, 32'(flush_e), 32'(exp));
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #1;
        check("rst_state", 32'(stall_state), 32'd0);
        check("rst_err", 32'(hazard_err), 32'd0);
        check("rst_lw", 32'(lw_stall_cnt), 32'd0);
        check("rst_br", 32'(br_stall_cnt), 32'd0);
        check_stall("rst_stall", 1'b0);
        #12 reset = 1'b1;
        step();

        // Load-use
        memto_reg_e = 1; rt_e = 8; rs_d = 8;
        #1;
        check_stall("lw_stall", 1'b1);
        step();
        check("lw_state", 32'(stall_state), 32'd1);
        check("lw_cnt", 32'(lw_stall_cnt), ecnt(1));
        idle();
        #1;
        check_stall("lw_rel", 1'b0);
        step();
        check("lw_back", 32'(stall_state), 32'd0);

        // Forwarding
        rs_e = 5; write_reg_m = 5; write_reg_w = 5;
        reg_write_m = 1; reg_write_w = 1;
        #1;
        check("fae_mem", 32'(forward_ae), 32'd2);
        check("fbe_rf", 32'(forward_be), 32'd0);
        reg_write_m = 0;
        #1;
        check("fae_wb", 32'(forward_ae), 32'd1);
        rs_e = 0;
        #1;
        check("fae_zero", 32'(forward_ae), 32'd0);
        rt_e = 7; write_reg_w = 7;
        #1;
        check("fbe_wb", 32'(forward_be), 32'd1);
        idle();
        rs_d = 5; write_reg_m = 5; reg_write_m = 1;
        #1;
        check("fad_hit", 32'(forward_ad), 32'd1);
        rs_d = 0; write_reg_m = 0;
        #1;
        check("fad_r0", 32'(forward_ad), 32'd0);
        idle();
        jump_d = 1; rs_d = 3; write_reg_e = 3; reg_write_e = 1;
        #1;
        check_stall("jump", 1'b0);
        idle();

        // Branch after ALU op, then forwarded next cycle
        branch_d = 1; reg_write_e = 1; write_reg_e = 9; rt_d = 9;
        #1;
        check_stall("br_stall", 1'b1);
        step();
        check("br_state", 32'(stall_state), 32'd2);
        check("br_cnt", 32'(br_stall_cnt), ecnt(1));
        reg_write_e = 0; write_reg_e = 0;
        write_reg_m = 9; reg_write_m = 1; memto_reg_m = 0;
        #1;
        check_stall("br_rel", 1'b0);
        check("fbd_hit", 32'(forward_bd), 32'd1);
        memto_reg_m = 1;
        #1;
        check_stall("br_load_m", 1'b1);
        check("br_lw_cnt", 32'(lw_stall_cnt), ecnt(1));
        idle();
        step();
        check("br_back", 32'(stall_state), 32'd0);

        // Watchdog: 3 consecutive stalls exceed WDOG_MAX=2
        memto_reg_e = 1; rt_e = 8; rs_d = 8;
        step();
        check("wd_1", 32'(stall_state), 32'd1);
        step();
        check("wd_2", 32'(stall_state), 32'd1);
        check("wd_2_err", 32'(hazard_err), 32'd0);
        step();
        check("wd_3", 32'(stall_state), 32'd3);
        check("wd_3_err", 32'(hazard_err), 32'd1);
        check("wd_lw_cnt", 32'(lw_stall_cnt), ecnt(4));
        idle();
        #1;
        check_stall("wd_err_comb", 1'b0);
        step();
        check("wd_rel_err", 32'(hazard_err), 32'd1);
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        check("wd_clr_err", 32'(hazard_err), 32'd1);
        check("wd_clr_st", 32'(stall_state), 32'd3);
        check("wd_clr_lw", 32'(lw_stall_cnt), ecnt(0));
        check("wd_clr_br", 32'(br_stall_cnt), ecnt(0));

        // Saturation
        memto_reg_e = 1; rt_e = 4; rt_d = 4;
        for (int i = 0; i < 20; i++) step();
        check("sat_lw", 32'(lw_stall_cnt), ecnt(20));
        check("sat_br", 32'(br_stall_cnt), ecnt(0));
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        check("clr_pri", 32'(lw_stall_cnt), ecnt(0));
        step();
        check("post_clr", 32'(lw_stall_cnt), ecnt(1));

        // Async reset between edges, stall inputs still active
        #2 reset = 1'b0;
        #1;
        check("ar_state", 32'(stall_state), 32'd0);
        check("ar_err", 32'(hazard_err), 32'd0);
        check("ar_lw", 32'(lw_stall_cnt), 32'd0);
        check_stall("ar_stall", 1'b1);
        reset = 1'b1;
        idle();
        step();
        check("ar_run", 32'(stall_state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Hazard-resolution block for the 5-stage MIPS pipeline datapath; consumes the datapath's register-index and control taps.
- Returns stall, flush and forwarding selects to the datapath.
- Detection and forwarding are combinational and take effect in the same cycle.
- Adds registered stall-cause tracking, a consecutive-stall watchdog with sticky error, and optional saturating performance counters.

Parameters:
CNT_W, 16, width of each performance counter.
WDOG_MAX, 2, maximum legal number of consecutive stall cycles; a longer run is an error.

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low
rs_d  in  5  Rs field in Decode
rt_d  in  5  Rt field in Decode
rs_e  in  5  Rs field in Execute
rt_e  in  5  Rt field in Execute
write_reg_e  in  5  destination register in Execute
write_reg_m  in  5  destination register in Memory
write_reg_w  in  5  destination register in Writeback
branch_d  in  1  Decode instruction is a branch
jump_d  in  1  Decode instruction is a jump; no hazard effect
reg_write_e  in  1  RegWrite in Execute
memto_reg_e  in  1  MemtoReg (load) in Execute
reg_write_m  in  1  RegWrite in Memory
memto_reg_m  in  1  MemtoReg in Memory
reg_write_w  in  1  RegWrite in Writeback
cnt_clr  in  1  synchronous clear of counters and watchdog run length
stall_f  out  1  hold PC
stall_d  out  1  hold Fetch/Decode register
flush_e  out  1  clear Decode/Execute register
forward_ad  out  1  branch comparator A source: 0 = RD1, 1 = ALUOutM
forward_bd  out  1  branch comparator B source: 0 = RD2, 1 = ALUOutM
forward_ae  out  2  ALU A source: 00 = RD1E, 01 = ResultW, 10 = ALUOutM
forward_be  out  2  ALU B source, same encoding as forward_ae
stall_state  out  2  registered cause: 00 RUN, 01 LW, 10 BR, 11 ERR
hazard_err  out  1  sticky watchdog error
lw_stall_cnt  out  CNT_W  load-use stall cycles
br_stall_cnt  out  CNT_W  branch stall cycles

Behaviour:
- Forward rule for X in {rs_e, rt_e}: 10 if X!=0 and X==write_reg_m and reg_write_m; else 01 if X!=0 and X==write_reg_w and reg_write_w; else 00. When M and W match simultaneously, M wins.
- forward_ad = rs_d!=0 and rs_d==write_reg_m and reg_write_m. forward_bd is the same with rt_d.
- lwstall = memto_reg_e and (rt_e==rs_d or rt_e==rt_d).
- brstall = branch_d and ((reg_write_e and write_reg_e in {rs_d, rt_d}) or (memto_reg_m and write_reg_m in {rs_d, rt_d})).
- stall_f = stall_d = flush_e = lwstall or brstall. All are combinational, with zero latency.
- jump_d alone never stalls.
- Register 0 is never forwarded. Register 0 is not excluded from stall detection, so a conservative stall is allowed.
- FSM, updated on the rising edge of clk:
  - RUN: goes to LW if lwstall, else to BR if brstall.
  - LW or BR: follows the current cause, with LW taking priority. Returns to RUN when there is no stall.
  - ERR: entered when the consecutive-stall run exceeds WDOG_MAX. ERR is absorbing until reset.
  - Stall, flush and forward outputs keep operating in ERR.
- Run counter:
  - Increments each stall cycle and saturates at WDOG_MAX+1.
  - Zeroes on a non-stall cycle or on cnt_clr.
  - cnt_clr does not leave ERR.
- hazard_err = (stall_state==ERR).
- Performance counters:
  - Increment by 1 per cycle with lwstall, or with brstall when lwstall is low (exclusive attribution).
  - Saturate at all-ones.
  - cnt_clr zeroes them and takes priority over an increment in the same cycle.
- Reset (asynchronous): stall_state=RUN, run counter=0, counters=0, hazard_err=0. Combinational outputs follow their inputs regardless of reset.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: lw_stall_cnt and br_stall_cnt are implemented as specified.
- Not defined: both outputs are tied to 0, no counter flops exist, and cnt_clr affects only the watchdog run counter.

Decomposition:
- Shared package: stall_state encodings (RUN/LW/BR/ERR), forward-select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10), and constant REG_ZERO=5'd0.
- One natural sub-module, fwd_sel: 2-bit forward select for one source operand. It is instantiated twice, for forward_ae and forward_be.

Test Plan:
- Load-use: memto_reg_e=1, rt_e=8, rs_d=8 -> stall_f/stall_d/flush_e=1 in the same cycle; stall_state=01 after the edge; lw_stall_cnt=1.
- Double forward: rs_e=5, write_reg_m=5, write_reg_w=5, reg_write_m=1, reg_write_w=1 -> forward_ae=10; drop reg_write_m -> forward_ae=01; set rs_e=0 -> forward_ae=00.
- Branch after ALU op: branch_d=1, reg_write_e=1, write_reg_e=9, rt_d=9 -> stall asserted, br_stall_cnt=1. Next cycle write_reg_m=9, reg_write_m=1, memto_reg_m=0 -> no stall, forward_bd=1.
- Watchdog: hold lwstall 3 consecutive cycles with WDOG_MAX=2 -> stall_state=11 and hazard_err=1 after the third edge; hazard_err stays 1 after stall release and after cnt_clr; clears only on reset low.
- Counter saturation (CNT_W=4): 20 lwstall cycles with hazard_err masked -> lw_stall_cnt=15. Pulse cnt_clr during a stall cycle -> count reads 0.
- Async reset mid-stall: assert reset low between edges -> stall_state=00 and counters=0 immediately; stall_f still reflects the inputs.
